// File: rtl/traffic_demand_sensor_if.sv
// +--------------------------------------------------------------------------+
// | Module   : traffic_demand_sensor_if                                      |
// | Purpose  : Detector, emergency and light bundle for the demand sensor.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface traffic_demand_sensor_if;
  logic       det_main;
  logic       det_left;
  logic       det_sec;
  logic       det_ped;
  logic       m_em_req;
  logic       s_em_req;
  logic [3:0] m_LRYG;
  logic [2:0] s_RYG;
  logic       ped;
  logic [2:0] main_num;
  logic [2:0] left_num;
  logic [2:0] sec_num;
  logic [2:0] p_num;
  logic       m_emergency;
  logic       s_emergency;
  logic       light_fault;

  modport master (
    output det_main, det_left, det_sec, det_ped, m_em_req, s_em_req,
    output m_LRYG, s_RYG, ped,
    input  main_num, left_num, sec_num, p_num,
    input  m_emergency, s_emergency, light_fault
  );

  modport slave (
    input  det_main, det_left, det_sec, det_ped, m_em_req, s_em_req,
    input  m_LRYG, s_RYG, ped,
    output main_num, left_num, sec_num, p_num,
    output m_emergency, s_emergency, light_fault
  );
endinterface

`default_nettype wire

// File: rtl/traffic_demand_sensor.sv
// +--------------------------------------------------------------------------+
// | Module   : traffic_demand_sensor                                         |
// | Purpose  : Debounced lane queue counters, emergency arbiter, light fault.|
// |            TRAFFIC_DEMAND_SYNC_EN adds 2-flop input synchronizers.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module traffic_demand_sensor #(
  parameter int GAP     = 4,
  parameter int EM_HOLD = 10
) (
  input  wire                     clk,
  input  wire                     rst,
  traffic_demand_sensor_if.slave  bus
);

  localparam logic [3:0] c_GAP  = 4'(GAP);
  localparam logic [7:0] c_HOLD = 8'(EM_HOLD);

  typedef enum logic [1:0] {
    EM_IDLE = 2'd0,
    EM_MAIN = 2'd1,
    EM_SEC  = 2'd2
  } em_state_t;

  logic [5:0]      w_raw;
  logic [5:0]      w_in;
  logic [3:0]      w_d;
  logic            w_m_req;
  logic            w_s_req;
  logic            w_s_onehot;
  logic            w_fault;
  logic [3:0]      w_served;
  logic [3:0][2:0] w_cnt;
  logic            r_fault;
  em_state_t       r_state;
  em_state_t       w_state_nxt;
  logic [7:0]      r_timer;
  logic [7:0]      w_timer_nxt;

  assign w_raw = {bus.s_em_req, bus.m_em_req, bus.det_ped,
                  bus.det_sec, bus.det_left, bus.det_main};

`ifdef TRAFFIC_DEMAND_SYNC_EN
  logic [5:0] r_sync_q1;
  logic [5:0] r_sync_q2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_q1 <= 6'd0;
      r_sync_q2 <= 6'd0;
    end else begin
      r_sync_q1 <= w_raw;
      r_sync_q2 <= r_sync_q1;
    end
  end

  assign w_in = r_sync_q2;
`else
  assign w_in = w_raw;
`endif

  assign w_d     = w_in[3:0];
  assign w_m_req = w_in[4];
  assign w_s_req = w_in[5];

  assign w_s_onehot = (bus.s_RYG == 3'b001) || (bus.s_RYG == 3'b010) ||
                      (bus.s_RYG == 3'b100);
  assign w_fault    = (bus.m_LRYG == 4'b1111) || !w_s_onehot ||
                      (bus.m_LRYG[0] && bus.s_RYG[0]);

  // An illegal light pattern serves nobody, so demand keeps accumulating.
  assign w_served = {bus.ped, bus.s_RYG[0], bus.m_LRYG[3], bus.m_LRYG[0]} &
                    {4{~w_fault}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       r_d_prev;
    logic [3:0] r_gap;
    logic [2:0] r_cnt;
    logic       w_accept;

    assign w_accept  = w_d[gi] && !r_d_prev && (r_gap == 4'd0);
    assign w_cnt[gi] = r_cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_d_prev <= 1'b0;
        r_gap    <= 4'd0;
        r_cnt    <= 3'd0;
      end else begin
        r_d_prev <= w_d[gi];
        if (w_accept) begin
          r_gap <= c_GAP;
        end else if (r_gap != 4'd0) begin
          r_gap <= r_gap - 4'd1;
        end
        if (w_served[gi]) begin
          r_cnt <= 3'd0;
        end else if (w_accept && (r_cnt != 3'd7)) begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fault <= 1'b0;
      r_state <= EM_IDLE;
      r_timer <= 8'd0;
    end else begin
      r_fault <= w_fault;
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // The hold timer counts down to 0 and the state leaves on the following
  // edge, giving exactly EM_HOLD cycles of output after the request drops.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      EM_IDLE: begin
        if (w_m_req) begin
          w_state_nxt = EM_MAIN;
          w_timer_nxt = c_HOLD;
        end else if (w_s_req) begin
          w_state_nxt = EM_SEC;
          w_timer_nxt = c_HOLD;
        end
      end
      EM_MAIN: begin
        if (w_m_req) begin
          w_timer_nxt = c_HOLD;
        end else if (r_timer == 8'd0) begin
          w_state_nxt = EM_IDLE;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      EM_SEC: begin
        if (w_m_req) begin
          w_state_nxt = EM_MAIN;
          w_timer_nxt = c_HOLD;
        end else if (w_s_req) begin
          w_timer_nxt = c_HOLD;
        end else if (r_timer == 8'd0) begin
          w_state_nxt = EM_IDLE;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_nxt = EM_IDLE;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

  assign bus.main_num    = w_cnt[0];
  assign bus.left_num    = w_cnt[1];
  assign bus.sec_num     = w_cnt[2];
  assign bus.p_num       = w_cnt[3];
  assign bus.m_emergency = (r_state == EM_MAIN);
  assign bus.s_emergency = (r_state == EM_SEC);
  assign bus.light_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_traffic_demand_sensor.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_traffic_demand_sensor                                      |
// | Purpose  : Directed vector table plus corner sequences for the sensor.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_traffic_demand_sensor;

`ifdef TRAFFIC_DEMAND_SYNC_EN
  localparam int c_SL = 2;
`else
  localparam int c_SL = 0;
`endif

  typedef struct {
    logic [3:0] det;
    logic [3:0] mlryg;
    logic [2:0] sryg;
    logic       ped;
    logic [2:0] e_m;
    logic [2:0] e_l;
    logic [2:0] e_s;
    logic [2:0] e_p;
    logic       e_f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [18];

  traffic_demand_sensor_if bus ();

  traffic_demand_sensor #(.GAP(4), .EM_HOLD(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int m, input int l,
                              input int s, input int p);
    check({tag, " main_num"}, 8'(bus.main_num), 8'(m));
    check({tag, " left_num"}, 8'(bus.left_num), 8'(l));
    check({tag, " sec_num"},  8'(bus.sec_num),  8'(s));
    check({tag, " p_num"},    8'(bus.p_num),    8'(p));
  endtask

  task automatic check_flags(input string tag, input int me, input int se, input int f);
    check({tag, " m_emergency"}, 8'(bus.m_emergency), 8'(me));
    check({tag, " s_emergency"}, 8'(bus.s_emergency), 8'(se));
    check({tag, " light_fault"}, 8'(bus.light_fault), 8'(f));
  endtask

  task automatic pulse(input int lane);
    case (lane)
      0: bus.det_main = 1'b1;
      1: bus.det_left = 1'b1;
      2: bus.det_sec  = 1'b1;
      default: bus.det_ped = 1'b1;
    endcase
    tick(1);
    {bus.det_ped, bus.det_sec, bus.det_left, bus.det_main} = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           det      m_LRYG   s_RYG   ped   main  left  sec   p     fault
    tbl[0]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0100, 3'b100, 1'b0, 3'd2, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd3, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd4, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd5, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[5]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd6, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd7, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd7, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0100, 3'b100, 1'b0, 3'd7, 3'd1, 3'd1, 3'd1, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0100, 3'b100, 1'b0, 3'd7, 3'd2, 3'd1, 3'd1, 1'b0};
    tbl[10] = '{4'b0001, 4'b0001, 3'b100, 1'b0, 3'd0, 3'd2, 3'd1, 3'd1, 1'b0};
    tbl[11] = '{4'b0100, 4'b0100, 3'b001, 1'b0, 3'd0, 3'd2, 3'd0, 3'd1, 1'b0};
    tbl[12] = '{4'b1000, 4'b0100, 3'b100, 1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 1'b0};
    tbl[13] = '{4'b0011, 4'b0100, 3'b100, 1'b0, 3'd1, 3'd3, 3'd0, 3'd0, 1'b0};
    tbl[14] = '{4'b0101, 4'b0001, 3'b001, 1'b0, 3'd2, 3'd3, 3'd1, 3'd0, 1'b1};
    tbl[15] = '{4'b0000, 4'b0100, 3'b011, 1'b0, 3'd2, 3'd3, 3'd1, 3'd0, 1'b1};
    tbl[16] = '{4'b1000, 4'b0100, 3'b000, 1'b1, 3'd2, 3'd3, 3'd1, 3'd1, 1'b1};
    tbl[17] = '{4'b0000, 4'b0100, 3'b100, 1'b0, 3'd2, 3'd3, 3'd1, 3'd1, 1'b0};

    {bus.det_ped, bus.det_sec, bus.det_left, bus.det_main} = 4'b0000;
    bus.m_em_req = 1'b0;
    bus.s_em_req = 1'b0;
    bus.m_LRYG   = 4'b0100;
    bus.s_RYG    = 3'b100;
    bus.ped      = 1'b0;

    tick(3);
    check_counts("reset", 0, 0, 0, 0);
    check_flags("reset", 0, 0, 0);
    rst = 1'b1;
    tick(2);

    for (int i = 0; i < 18; i++) begin
      bus.m_LRYG = tbl[i].mlryg;
      bus.s_RYG  = tbl[i].sryg;
      bus.ped    = tbl[i].ped;
      {bus.det_ped, bus.det_sec, bus.det_left, bus.det_main} = tbl[i].det;
      tick(1);
      {bus.det_ped, bus.det_sec, bus.det_left, bus.det_main} = 4'b0000;
      tick(6);
      check_counts($sformatf("vec%0d", i), int'(tbl[i].e_m), int'(tbl[i].e_l),
                   int'(tbl[i].e_s), int'(tbl[i].e_p));
      check_flags($sformatf("vec%0d", i), 0, 0, int'(tbl[i].e_f));
    end

    // Debounce: second pulse two cycles later is swallowed, one six later is not.
    pulse(2);
    tick(1);
    pulse(2);
    tick(3);
    check("gap second pulse sec_num", 8'(bus.sec_num), 8'd2);
    pulse(2);
    tick(6);
    check("gap third pulse sec_num", 8'(bus.sec_num), 8'd3);

    // Left lane served by left arrow, resumes counting after.
    pulse(1);
    tick(6);
    pulse(1);
    tick(6);
    check("left preload", 8'(bus.left_num), 8'd5);
    bus.m_LRYG = 4'b1100;
    tick(1);
    check("left served clear", 8'(bus.left_num), 8'd0);
    pulse(1);
    tick(6);
    check("left served pulse", 8'(bus.left_num), 8'd0);
    bus.m_LRYG = 4'b0100;
    tick(1);
    pulse(1);
    tick(6);
    check("left resume", 8'(bus.left_num), 8'd1);

    // All main lamps lit: fault for three cycles, main still counts.
    check("fault before", 8'(bus.light_fault), 8'd0);
    bus.m_LRYG   = 4'b1111;
    bus.det_main = 1'b1;
    tick(1);
    bus.det_main = 1'b0;
    check("fault cycle1", 8'(bus.light_fault), 8'd1);
    tick(1);
    check("fault cycle2", 8'(bus.light_fault), 8'd1);
    tick(1);
    check("fault cycle3", 8'(bus.light_fault), 8'd1);
    bus.m_LRYG = 4'b0100;
    tick(1);
    check("fault cleared", 8'(bus.light_fault), 8'd0);
    tick(5);
    check("fault main_num", 8'(bus.main_num), 8'd3);

    // Secondary emergency preempted by main, then main hold.
    bus.s_em_req = 1'b1;
    tick(1 + c_SL);
    check_flags("em sec", 0, 1, 0);
    tick(4 - c_SL);
    bus.m_em_req = 1'b1;
    tick(c_SL);
    check_flags("em pre", 0, 1, 0);
    tick(1);
    check_flags("em preempt", 1, 0, 0);
    tick(3);
    bus.m_em_req = 1'b0;
    bus.s_em_req = 1'b0;
    for (int i = 1; i <= 11 + c_SL; i++) begin
      tick(1);
      check($sformatf("hold%0d m_emergency", i), 8'(bus.m_emergency),
            (i <= 10 + c_SL) ? 8'd1 : 8'd0);
      check($sformatf("hold%0d s_emergency", i), 8'(bus.s_emergency), 8'd0);
    end

    // Reset mid-hold with a pedestrian backlog and detector held high.
    pulse(3);
    tick(6);
    pulse(3);
    tick(6);
    check("ped preload", 8'(bus.p_num), 8'd3);
    bus.m_em_req = 1'b1;
    tick(2 + c_SL);
    bus.m_em_req = 1'b0;
    tick(3);
    check("hold before reset", 8'(bus.m_emergency), 8'd1);
    rst         = 1'b0;
    bus.det_ped = 1'b1;
    tick(1);
    check_counts("in reset", 0, 0, 0, 0);
    check_flags("in reset", 0, 0, 0);
    tick(2);
    rst = 1'b1;
    tick(3 + c_SL);
    check_counts("post reset", 0, 0, 0, 1);
    check_flags("post reset", 0, 0, 0);
    bus.det_ped = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
